// File: rtl/tensor_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tensor_cfg_arbiter
// Purpose  : Round-robin arbiter that lets NUM_REQ config requesters share
//            one tensor interface, keeping at most one operation in flight.
//            It issues a registered config, waits for op_done and then
//            returns a done pulse to the requester that owns the operation.
// Options  : define TENSOR_ARB_TIMEOUT_EN to enable the WAIT watchdog
//            (TIMEOUT_CYCLES); without it timeout_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module tensor_cfg_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CFG_W          = 107,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ*CFG_W-1:0]     req_tdata,
  input  logic [NUM_REQ-1:0]           req_tvalid,
  output logic [NUM_REQ-1:0]           req_tready,
  output logic [CFG_W-1:0]             cfg_tdata,
  output logic                         cfg_tvalid,
  input  logic                         cfg_tready,
  input  logic                         op_done,
  output logic [NUM_REQ-1:0]           done,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [CFG_W-1:0]   cfg_tdata_q, cfg_tdata_d;
  logic               cfg_tvalid_q, cfg_tvalid_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] ready_w;

  // round-robin search results
  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [CFG_W-1:0]   win_data;
  int                 cand;
  logic [ID_W-1:0]    cand_idx;

  // A timeout limit below 2 would let the watchdog fire in the WAIT entry
  // cycle; such a setting is left visible as a distinct, empty scope.
  if (TIMEOUT_CYCLES >= 2) begin : g_timeout_limit_ok
  end else begin : g_timeout_limit_degenerate
  end

`ifdef TENSOR_ARB_TIMEOUT_EN
  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_err_q, timeout_err_d;
`endif

  // Pick the first valid requester after last_grant, wrapping around.
  // Scanning from the farthest candidate down lets the nearest one win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(last_grant_q) + 1 + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = cand[ID_W-1:0];
      if (req_tvalid[cand_idx]) begin
        win_found         = 1'b1;
        win_idx           = cand_idx;
        win_oh            = '0;
        win_oh[cand_idx]  = 1'b1;
      end
    end
  end

  // Select the winner's config word using the one-hot grant.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_data = req_tdata[i*CFG_W +: CFG_W];
      end
    end
  end

  // Next-state, accept and completion logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    cfg_tdata_d  = cfg_tdata_q;
    cfg_tvalid_d = cfg_tvalid_q;
    done_d       = '0;
    ready_w      = '0;
`ifdef TENSOR_ARB_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found && !reset) begin
          ready_w      = win_oh;
          cfg_tdata_d  = win_data;
          cfg_tvalid_d = 1'b1;
          grant_id_d   = win_idx;
          last_grant_d = win_idx;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cfg_tready) begin
          cfg_tvalid_d = 1'b0;
          state_d      = ST_WAIT;
`ifdef TENSOR_ARB_TIMEOUT_EN
          wd_cnt_d     = '0;
`endif
        end
      end
      ST_WAIT: begin
        // op_done wins over a watchdog expiry in the same cycle
        if (op_done) begin
          done_d[grant_id_q] = 1'b1;
          state_d            = ST_IDLE;
        end
`ifdef TENSOR_ARB_TIMEOUT_EN
        else if (wd_cnt_q == C_TO_LAST) begin
          done_d[grant_id_q] = 1'b1;
          timeout_err_d      = 1'b1;
          state_d            = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      cfg_tdata_q  <= '0;
      cfg_tvalid_q <= 1'b0;
      done_q       <= '0;
`ifdef TENSOR_ARB_TIMEOUT_EN
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      cfg_tdata_q  <= cfg_tdata_d;
      cfg_tvalid_q <= cfg_tvalid_d;
      done_q       <= done_d;
`ifdef TENSOR_ARB_TIMEOUT_EN
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign req_tready = ready_w;
  assign cfg_tdata  = cfg_tdata_q;
  assign cfg_tvalid = cfg_tvalid_q;
  assign done       = done_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef TENSOR_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tensor_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tensor_cfg_arbiter
// Purpose  : Self-checking bench for tensor_cfg_arbiter: directed scenarios
//            plus a randomized run against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tensor_cfg_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CFG_W   = 107;
  localparam int TO      = 16;
  localparam int ID_W    = 2;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic [NUM_REQ*CFG_W-1:0]   req_tdata = '0;
  logic [NUM_REQ-1:0]         req_tvalid = '0;
  logic [NUM_REQ-1:0]         req_tready;
  logic [CFG_W-1:0]           cfg_tdata;
  logic                       cfg_tvalid;
  logic                       cfg_tready = 1'b0;
  logic                       op_done = 1'b0;
  logic [NUM_REQ-1:0]         done;
  logic [ID_W-1:0]            grant_id;
  logic                       busy;
  logic                       timeout_err;

  int errors = 0;
  int checks = 0;

  tensor_cfg_arbiter #(
    .NUM_REQ(NUM_REQ), .CFG_W(CFG_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .req_tdata(req_tdata), .req_tvalid(req_tvalid),
    .req_tready(req_tready), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
    .cfg_tready(cfg_tready), .op_done(op_done), .done(done), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [CFG_W-1:0] rand_cfg();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[CFG_W-1:0];
  endfunction

  task automatic rand_all_data();
    for (int i = 0; i < NUM_REQ; i++) req_tdata[i*CFG_W +: CFG_W] = rand_cfg();
  endtask

  // First valid requester after 'last', wrapping; -1 if none.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; req_tvalid = '0; cfg_tready = 1'b0; op_done = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_tvalid = '1; op_done = 1'b1; cfg_tready = 1'b1;
    rand_all_data();
    step();
    checks++;
    if (req_tready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b want 0000", req_tready);
    end
    checks++;
    if ({cfg_tvalid, busy, done, grant_id, timeout_err} !== 9'b0 || cfg_tdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b busy=%b done=%b gid=%0d to=%b data=%h want all 0",
               cfg_tvalid, busy, done, grant_id, timeout_err, cfg_tdata);
    end
    reset = 1'b0; req_tvalid = '0; op_done = 1'b0; cfg_tready = 1'b0;
  endtask

  task automatic test_single();
    logic [111:0] pat;
    logic [CFG_W-1:0] d;
    do_reset();
    pat = {14{8'h5A}};
    d = pat[CFG_W-1:0];
    rand_all_data();
    req_tdata[0 +: CFG_W] = d;
    req_tvalid = 4'b0001; cfg_tready = 1'b1;
    #1;
    checks++;
    if (req_tready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: got %b want 0001", req_tready);
    end
    step();
    req_tvalid = '0;
    checks++;
    if (cfg_tvalid !== 1'b1 || cfg_tdata !== d || grant_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: got v=%b gid=%0d busy=%b data=%h want v=1 gid=0 busy=1 data=%h",
               cfg_tvalid, grant_id, busy, cfg_tdata, d);
    end
    step();
    checks++;
    if (cfg_tvalid !== 1'b0 || busy !== 1'b1 || done !== 4'b0) begin
      errors++;
      $display("FAIL single_wait: got v=%b busy=%b done=%b want v=0 busy=1 done=0000",
               cfg_tvalid, busy, done);
    end
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    checks++;
    if (done !== 4'b0001 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: got done=%b busy=%b want 0001 0", done, busy);
    end
    step();
    checks++;
    if (done !== 4'b0000) begin
      errors++; $display("FAIL single_done_pulse: got %b want 0000", done);
    end
  endtask

  task automatic test_round_robin();
    int exp;
    logic [CFG_W-1:0] d;
    do_reset();
    rand_all_data();
    req_tvalid = 4'b1111; cfg_tready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp = n % NUM_REQ;
      d = req_tdata[exp*CFG_W +: CFG_W];
      #1;
      checks++;
      if (req_tready !== 4'(1 << exp)) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b want %b", n, req_tready, 4'(1 << exp));
      end
      step();
      checks++;
      if (grant_id !== ID_W'(exp) || cfg_tvalid !== 1'b1 || cfg_tdata !== d) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got gid=%0d v=%b data=%h want gid=%0d v=1 data=%h",
                 n, grant_id, cfg_tvalid, cfg_tdata, exp, d);
      end
      checks++;
      if (req_tready !== 4'b0000) begin
        errors++; $display("FAIL rr_busy_ready[%0d]: got %b want 0000", n, req_tready);
      end
      step();
      op_done = 1'b1;
      step();
      op_done = 1'b0;
      checks++;
      if (done !== 4'(1 << exp)) begin
        errors++; $display("FAIL rr_done[%0d]: got %b want %b", n, done, 4'(1 << exp));
      end
    end
    req_tvalid = '0;
    step();
  endtask

  task automatic test_backpressure();
    logic [CFG_W-1:0] d2;
    do_reset();
    rand_all_data();
    d2 = req_tdata[2*CFG_W +: CFG_W];
    req_tvalid = 4'b0100; cfg_tready = 1'b0;
    #1;
    checks++;
    if (req_tready !== 4'b0100) begin
      errors++; $display("FAIL bp_ready: got %b want 0100", req_tready);
    end
    step();
    req_tvalid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      rand_all_data();
      #1;
      checks++;
      if (cfg_tvalid !== 1'b1 || cfg_tdata !== d2 || req_tready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b ready=%b data=%h want v=1 ready=0000 data=%h",
                 n, cfg_tvalid, req_tready, cfg_tdata, d2);
      end
      step();
    end
    cfg_tready = 1'b1;
    step();
    checks++;
    if (cfg_tvalid !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd2 || req_tready !== 4'b0000) begin
      errors++;
      $display("FAIL bp_wait: got v=%b busy=%b gid=%0d ready=%b want v=0 busy=1 gid=2 ready=0000",
               cfg_tvalid, busy, grant_id, req_tready);
    end
    op_done = 1'b1; req_tvalid = '0;
    step();
    op_done = 1'b0;
    checks++;
    if (done !== 4'b0100) begin
      errors++; $display("FAIL bp_done: got %b want 0100", done);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    op_done = 1'b1;
    step(); step();
    op_done = 1'b0;
    checks++;
    if (done !== 4'b0 || busy !== 1'b0 || cfg_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL spur_idle: got done=%b busy=%b v=%b want 0000 0 0", done, busy, cfg_tvalid);
    end
    rand_all_data();
    req_tvalid = 4'b0010; cfg_tready = 1'b0;
    step();
    req_tvalid = '0; op_done = 1'b1;
    step();
    checks++;
    if (cfg_tvalid !== 1'b1 || done !== 4'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL spur_issue: got v=%b done=%b busy=%b want 1 0000 1", cfg_tvalid, done, busy);
    end
    op_done = 1'b0; cfg_tready = 1'b1;
    step();
    op_done = 1'b1; req_tvalid = 4'b0100;
    #1;
    checks++;
    if (req_tready !== 4'b0000) begin
      errors++; $display("FAIL spur_leave_ready: got %b want 0000", req_tready);
    end
    step();
    op_done = 1'b0;
    checks++;
    if (done !== 4'b0010) begin
      errors++; $display("FAIL spur_done: got %b want 0010", done);
    end
    #1;
    checks++;
    if (req_tready !== 4'b0100) begin
      errors++; $display("FAIL spur_next_ready: got %b want 0100", req_tready);
    end
    step();
    req_tvalid = '0;
    checks++;
    if (cfg_tvalid !== 1'b1 || grant_id !== 2'd2) begin
      errors++; $display("FAIL spur_next_grant: got v=%b gid=%0d want 1 2", cfg_tvalid, grant_id);
    end
    step();
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    rand_all_data();
    req_tvalid = 4'b0010; cfg_tready = 1'b1;
    step();
    req_tvalid = '0;
    step();
    reset = 1'b1; op_done = 1'b1;
    step();
    reset = 1'b0; op_done = 1'b0;
    checks++;
    if ({cfg_tvalid, busy, done, grant_id, timeout_err} !== 9'b0 || cfg_tdata !== '0) begin
      errors++;
      $display("FAIL rstwait_outputs: got v=%b busy=%b done=%b gid=%0d to=%b data=%h want all 0",
               cfg_tvalid, busy, done, grant_id, timeout_err, cfg_tdata);
    end
    step();
    checks++;
    if (done !== 4'b0) begin
      errors++; $display("FAIL rstwait_no_done: got %b want 0000", done);
    end
    req_tvalid = 4'b1111;
    #1;
    checks++;
    if (req_tready !== 4'b0001) begin
      errors++; $display("FAIL rstwait_prio: got %b want 0001", req_tready);
    end
    step();
    req_tvalid = '0;
  endtask

`ifdef TENSOR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    rand_all_data();
    req_tvalid = 4'b1000; cfg_tready = 1'b1;
    step();
    req_tvalid = '0;
    step();
    for (int k = 1; k <= TO; k++) begin
      step();
      checks++;
      if (k < TO) begin
        if (timeout_err !== 1'b0 || done !== 4'b0) begin
          errors++; $display("FAIL to_early[%0d]: got to=%b done=%b want 0 0000", k, timeout_err, done);
        end
      end else begin
        if (timeout_err !== 1'b1 || done !== 4'b1000 || busy !== 1'b0) begin
          errors++;
          $display("FAIL to_fire: got to=%b done=%b busy=%b want 1 1000 0", timeout_err, done, busy);
        end
      end
    end
    step();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL to_pulse: got %b want 0", timeout_err);
    end
    req_tvalid = 4'b1000;
    step();
    req_tvalid = '0;
    step();
    for (int k = 1; k < TO; k++) step();
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || done !== 4'b1000) begin
      errors++; $display("FAIL to_tie: got to=%b done=%b want 0 1000", timeout_err, done);
    end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    rand_all_data();
    req_tvalid = 4'b1000; cfg_tready = 1'b1;
    step();
    req_tvalid = '0;
    step();
    for (int k = 0; k < 40; k++) begin
      step();
      checks++;
      if (busy !== 1'b1 || timeout_err !== 1'b0 || done !== 4'b0) begin
        errors++;
        $display("FAIL nto_hold[%0d]: got busy=%b to=%b done=%b want 1 0 0000", k, busy, timeout_err, done);
      end
    end
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    checks++;
    if (done !== 4'b1000) begin
      errors++; $display("FAIL nto_done: got %b want 1000", done);
    end
  endtask
`endif

  task automatic test_random();
    int phase, last, wcnt, w;
    logic exp_valid, exp_to;
    logic [CFG_W-1:0] exp_data;
    logic [ID_W-1:0] exp_gid;
    logic [NUM_REQ-1:0] exp_done, exp_ready;
    do_reset();
    phase = 0; last = NUM_REQ - 1; wcnt = 0;
    exp_valid = 1'b0; exp_data = '0; exp_gid = '0;
    for (int n = 0; n < 400; n++) begin
      req_tvalid = 4'($urandom_range(0, 15));
      rand_all_data();
      cfg_tready = 1'($urandom_range(0, 1));
      op_done = ($urandom_range(0, 3) == 0);
      #1;
      w = rr_pick(req_tvalid, last);
      exp_ready = (phase == 0 && w >= 0) ? 4'(1 << w) : 4'b0;
      checks++;
      if (req_tready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, req_tready, exp_ready);
      end
      exp_done = '0; exp_to = 1'b0;
      if (phase == 0) begin
        if (w >= 0) begin
          exp_data = req_tdata[w*CFG_W +: CFG_W];
          exp_gid = ID_W'(w); last = w; exp_valid = 1'b1; phase = 1;
        end
      end else if (phase == 1) begin
        if (cfg_tready) begin exp_valid = 1'b0; phase = 2; wcnt = 0; end
      end else begin
        if (op_done) begin
          exp_done = 4'(1 << exp_gid); phase = 0;
        end
`ifdef TENSOR_ARB_TIMEOUT_EN
        else if (wcnt == TO - 1) begin
          exp_done = 4'(1 << exp_gid); exp_to = 1'b1; phase = 0;
        end else begin
          wcnt++;
        end
`endif
      end
      step();
      checks++;
      if ({cfg_tvalid, busy, done, grant_id, timeout_err} !== {exp_valid, (phase != 0), exp_done, exp_gid, exp_to}) begin
        errors++;
        $display("FAIL rnd_ctrl[%0d]: got v=%b busy=%b done=%b gid=%0d to=%b want v=%b busy=%b done=%b gid=%0d to=%b",
                 n, cfg_tvalid, busy, done, grant_id, timeout_err,
                 exp_valid, (phase != 0), exp_done, exp_gid, exp_to);
      end
      checks++;
      if (cfg_tdata !== exp_data) begin
        errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, cfg_tdata, exp_data);
      end
    end
    req_tvalid = '0; op_done = 1'b0; cfg_tready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_spurious();
    test_reset_mid_wait();
`ifdef TENSOR_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
